// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
package decoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int unsigned OH_LOG = 10;
   localparam int unsigned OH_MAX = 1 << OH_LOG;

   // Callers truncate the result to their own output width; codes at or above width give zero.
   function automatic logic [OH_MAX-1:0] onehot(input int unsigned code, input int unsigned width);
      logic [OH_MAX-1:0] oh;
      oh = '0;
      if (code < width && code < OH_MAX) oh[code[OH_LOG-1:0]] = 1'b1;
      return oh;
   endfunction

   function automatic bit used_legal(input int unsigned n, input int unsigned used);
      return (used >= 1) && (used <= (32'd1 << n));
   endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Loadable down-counter that sets how long each scan line is held.
module dwell_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)            cnt_d = value_i;
      else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with out-of-range flag and autonomous line scan.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned USED    = 1 << N,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 mode_i,
   input  logic [N-1:0]         d_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 loop_i,
   input  logic [DWELL_W-1:0]   dwell_i,
   output logic [(1<<N)-1:0]    y_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int unsigned OUTW   = 1 << N;
   localparam logic [N-1:0] LAST  = N'(USED - 1);
   localparam logic [N:0]  USED_W = (N+1)'(USED);

   if (!used_legal(N, USED)) begin : g_bad_used
      $error("decoder_scan: USED must lie in 1..2**N");
   end

   state_e            state_q, state_d;
   logic [N-1:0]      idx_q, idx_d;
   logic [OUTW-1:0]   y_q, y_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              load;
   logic              dwell_zero;

   dwell_timer #(.W(DWELL_W)) u_timer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .value_i (dwell_i),
      .zero_o  (dwell_zero)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;

      if (!en_i) begin
         state_d = IDLE;
         y_d     = '0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!mode_i) begin
                  y_d   = OUTW'(onehot(32'(d_i), USED));
                  err_d = ({1'b0, d_i} >= USED_W);
               end else if (start_i && !stop_i) begin
                  state_d = SCAN;
                  idx_d   = '0;
                  load    = 1'b1;
                  y_d     = OUTW'(1);
                  busy_d  = 1'b1;
               end else begin
                  y_d = '0;
               end
            end
            SCAN: begin
               if (stop_i || !mode_i) begin
                  state_d = IDLE;
                  y_d     = '0;
                  busy_d  = 1'b0;
               end else if (!dwell_zero) begin
                  // counter is decrementing inside the timer; line holds
               end else if (idx_q < LAST) begin
                  idx_d = idx_q + 1'b1;
                  load  = 1'b1;
                  y_d   = OUTW'(onehot(32'(idx_q) + 32'd1, USED));
               end else if (loop_i) begin
                  idx_d = '0;
                  load  = 1'b1;
                  y_d   = OUTW'(1);
               end else begin
                  state_d = IDLE;
                  y_d     = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               y_d     = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign y_o    = y_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: per-cycle behavioural model plus hand-computed checkpoints.
module tb_decoder_scan;

   localparam int USED = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [2:0] d = '0;
   logic [7:0] dwell = '0;

   logic [7:0] y0, y1;
   logic       busy0, done0, err0, busy1, done1, err1;

   int  n_chk = 0;
   int  n_fail = 0;
   bit  chk_en = 1'b0;

   always #5 clk = ~clk;

   decoder_scan #(.N(3), .USED(USED), .DWELL_W(8)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .d_i(d),
      .start_i(start), .stop_i(stop), .loop_i(loop), .dwell_i(dwell),
      .y_o(y0), .busy_o(busy0), .done_o(done0), .err_o(err0)
   );

   decoder_scan #(.N(3), .USED(1), .DWELL_W(8)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .d_i(d),
      .start_i(start), .stop_i(stop), .loop_i(loop), .dwell_i(dwell),
      .y_o(y1), .busy_o(busy1), .done_o(done1), .err_o(err1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: scan tracked as (line, cycles held so far, hold length fixed when the line began).
   bit         m_scan;
   int         m_line, m_held, m_len;
   logic [7:0] m_y;
   bit         m_done, m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_scan = 0; m_line = 0; m_held = 0; m_len = 0;
         m_y = '0; m_done = 0; m_err = 0;
      end else begin
         m_done = 0;
         m_err  = 0;
         if (!en) begin
            m_scan = 0; m_y = '0;
         end else if (!m_scan) begin
            if (!mode) begin
               m_y   = (int'(d) < USED) ? (8'd1 << d) : 8'd0;
               m_err = (int'(d) >= USED);
            end else if (start && !stop) begin
               m_scan = 1; m_line = 0; m_held = 1; m_len = int'(dwell) + 1; m_y = 8'd1;
            end else begin
               m_y = '0;
            end
         end else begin
            if (stop || !mode) begin
               m_scan = 0; m_y = '0;
            end else if (m_held < m_len) begin
               m_held++;
            end else if (m_line < USED - 1) begin
               m_line++; m_held = 1; m_len = int'(dwell) + 1; m_y = 8'd1 << m_line;
            end else if (loop) begin
               m_line = 0; m_held = 1; m_len = int'(dwell) + 1; m_y = 8'd1;
            end else begin
               m_scan = 0; m_y = '0; m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("model_y",    32'(y0),    32'(m_y));
         chk("model_busy", 32'(busy0), 32'(m_scan));
         chk("model_done", 32'(done0), 32'(m_done));
         chk("model_err",  32'(err0),  32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset_y",    32'(y0),    0);
      chk("reset_busy", 32'(busy0), 0);
      chk("reset_done", 32'(done0), 0);
      chk("reset_err",  32'(err0),  0);
      tick(); tick();
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // direct decode
      en = 1; mode = 0; d = 3'd5;
      tick();
      chk("direct_d5_y", 32'(y0), 32'h20);
      chk("direct_d5_err", 32'(err0), 0);
      d = 3'd6;
      tick();
      chk("direct_d6_y", 32'(y0), 0);
      chk("direct_d6_err", 32'(err0), 1);
      d = 3'd7;
      tick();
      chk("direct_d7_err", 32'(err0), 1);
      d = 3'd0;
      tick();
      chk("direct_d0_y", 32'(y0), 32'h01);
      en = 0; d = 3'd3;
      tick();
      chk("en_low_y", 32'(y0), 0);
      chk("en_low_err", 32'(err0), 0);

      // non-loop scan, dwell=1: each line held 2 cycles, done 12 edges after start
      en = 1; mode = 1; dwell = 8'd1; loop = 0; start = 1;
      tick();
      start = 0;
      chk("scan_first_y", 32'(y0), 32'h01);
      chk("scan_first_busy", 32'(busy0), 1);
      for (int k = 1; k <= 13; k++) begin
         tick();
         chk("scan_seq_y", 32'(y0), (k < 12) ? (32'd1 << (k / 2)) : 32'd0);
         chk("scan_seq_done", 32'(done0), (k == 12) ? 32'd1 : 32'd0);
         chk("scan_seq_busy", 32'(busy0), (k < 12) ? 32'd1 : 32'd0);
      end

      // loop scan, then stop
      loop = 1; start = 1;
      tick();
      start = 0;
      for (int k = 1; k <= 11; k++) tick();
      chk("loop_last_y", 32'(y0), 32'h20);
      tick();
      chk("loop_wrap_y", 32'(y0), 32'h01);
      chk("loop_wrap_done", 32'(done0), 0);
      chk("loop_wrap_busy", 32'(busy0), 1);
      stop = 1;
      tick();
      stop = 0;
      chk("loop_stop_y", 32'(y0), 0);
      chk("loop_stop_busy", 32'(busy0), 0);
      chk("loop_stop_done", 32'(done0), 0);

      // start and stop together: stays idle
      loop = 0; start = 1; stop = 1;
      tick();
      start = 0; stop = 0;
      chk("collide_busy", 32'(busy0), 0);
      chk("collide_y", 32'(y0), 0);

      // start while busy is ignored
      start = 1;
      tick();
      start = 0;
      for (int k = 1; k <= 3; k++) tick();
      start = 1;
      tick();
      start = 0;
      chk("restart_ignored_y", 32'(y0), 32'h04);
      for (int k = 5; k <= 13; k++) tick();
      chk("restart_idle_busy", 32'(busy0), 0);

      // dwell 1 -> 3 during line 2: lines 3..5 held 4 cycles
      dwell = 8'd1; start = 1;
      tick();
      start = 0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 4) dwell = 8'd3;
         if (k == 9)  chk("dwell_line3_end", 32'(y0), 32'h08);
         if (k == 10) chk("dwell_line4_start", 32'(y0), 32'h10);
         if (k == 17) chk("dwell_line5_end", 32'(y0), 32'h20);
         if (k == 18) chk("dwell_done", 32'(done0), 1);
      end
      tick();
      dwell = 8'd1;

      // mode drops mid-scan: abort, then direct decode
      start = 1;
      tick();
      start = 0;
      tick(); tick();
      mode = 0; d = 3'd2;
      tick();
      chk("mode_drop_y", 32'(y0), 0);
      chk("mode_drop_busy", 32'(busy0), 0);
      chk("mode_drop_done", 32'(done0), 0);
      tick();
      chk("mode_drop_direct", 32'(y0), 32'h04);

      // asynchronous reset mid-scan
      mode = 1; start = 1;
      tick();
      start = 0;
      tick(); tick();
      rst_n = 0;
      #1;
      chk("async_rst_y", 32'(y0), 0);
      chk("async_rst_busy", 32'(busy0), 0);
      chk("async_rst_done", 32'(done0), 0);
      tick();
      rst_n = 1;

      // USED=1, dwell=0 corner on the second instance
      dwell = 8'd0; start = 1;
      tick();
      start = 0;
      chk("used1_y", 32'(y1), 32'h01);
      chk("used1_busy", 32'(busy1), 1);
      tick();
      chk("used1_end_y", 32'(y1), 0);
      chk("used1_done", 32'(done1), 1);
      chk("used1_end_busy", 32'(busy1), 0);
      tick();
      chk("used1_done_pulse", 32'(done1), 0);

      en = 0;
      tick(); tick();
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
